// File: rtl/dc_ipu_box_accumulator.sv
// Box accumulator feeding the IPU array divider: sums up to `ratio` pixels per window
// and hands (sum, cnt) downstream over valid/ready. Define DC_IPU_BOX_ACC_ROUND_EN for round-to-nearest bias.
module dc_ipu_box_accumulator #(
  parameter int PIX_WIDTH = 8,
  parameter int CNT_WIDTH = 4,
  localparam int SUM_WIDTH = PIX_WIDTH + CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] ratio,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_WIDTH-1:0] pix,
  input  logic                 pix_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_WIDTH-1:0] sum,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 out_last
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both high;
  // in_ready = !out_valid | out_ready, so a stalled result blocks new pixels.

  logic [SUM_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic                 out_valid_q, out_valid_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 last_q, last_d;

  logic [CNT_WIDTH-1:0] ratio_eff;
  logic [CNT_WIDTH:0]   n_inc;
  logic [SUM_WIDTH-1:0] sum_raw;
  logic [SUM_WIDTH-1:0] sum_res;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 win_close;

  assign in_ready  = !out_valid_q || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;

  assign ratio_eff = (ratio == '0) ? CNT_WIDTH'(1) : ratio;
  assign n_inc     = {1'b0, n_q} + (CNT_WIDTH+1)'(1);
  // n only grows while n+1 < ratio, so n_inc never exceeds the max window size.
  assign win_close = (n_inc >= {1'b0, ratio_eff}) || pix_last;
  assign sum_raw   = acc_q + SUM_WIDTH'(pix);

`ifdef DC_IPU_BOX_ACC_ROUND_EN
  // Half the divisor added so the divider's truncation becomes round-to-nearest.
  assign sum_res = sum_raw + SUM_WIDTH'(n_inc >> 1);
`else
  assign sum_res = sum_raw;
`endif

  always_comb begin
    acc_d       = acc_q;
    n_d         = n_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    if (clr) begin
      acc_d       = '0;
      n_d         = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_xfer) out_valid_d = 1'b0;
      if (in_xfer) begin
        if (win_close) begin
          sum_d       = sum_res;
          cnt_d       = n_inc[CNT_WIDTH-1:0];
          last_d      = pix_last;
          out_valid_d = 1'b1;
          acc_d       = '0;
          n_d         = '0;
        end else begin
          acc_d = sum_raw;
          n_d   = n_inc[CNT_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc_q       <= '0;
      n_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cnt       = cnt_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_dc_ipu_box_accumulator.sv
// Directed bench for dc_ipu_box_accumulator: expected results are queued by the stimulus
// and consumed by an independent output monitor.
module tb_dc_ipu_box_accumulator;

  localparam int PW = 8;
  localparam int CW = 4;
  localparam int SW = PW + CW;
  localparam int W  = SW + CW + 1;

  logic          clk;
  logic          nreset;
  logic          clr;
  logic [CW-1:0] ratio;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] pix;
  logic          pix_last;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] sum;
  logic [CW-1:0] cnt;
  logic          out_last;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  dc_ipu_box_accumulator #(.PIX_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .nreset(nreset), .clr(clr), .ratio(ratio),
    .in_valid(in_valid), .in_ready(in_ready), .pix(pix), .pix_last(pix_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cnt(cnt), .out_last(out_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SW-1:0] exp_sum(input int raw, input int c);
`ifdef DC_IPU_BOX_ACC_ROUND_EN
    return SW'(raw + (c >> 1));
`else
    return SW'(raw);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int raw, input int c, input logic l);
    logic [SW-1:0] s;
    logic [CW-1:0] cc;
    s  = exp_sum(raw, c);
    cc = CW'(c);
    exp_q.push_back({s, cc, l});
  endtask

  // driver: called #1 after a rising edge, returns #1 after the accepting edge
  task automatic send(input int p, input logic l, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    pix      = PW'(p);
    pix_last = l;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    pix_last = 1'b0;
  endtask

  task automatic send_n(input int p, input logic l);
    int w;
    send(p, l, w);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (nreset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got sum=%0d cnt=%0d last=%0d expected none", sum, cnt, out_last);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if ({sum, cnt, out_last} != e) begin
          n_fail++;
          $display("FAIL out: got sum=%0d cnt=%0d last=%0d expected sum=%0d cnt=%0d last=%0d",
                   sum, cnt, out_last, e[W-1:CW+1], e[CW:1], e[0]);
        end
      end
    end
  end

  initial begin
    int w;
    int t;
    nreset = 1'b0; clr = 1'b0; ratio = 4'd3; in_valid = 1'b0;
    pix = '0; pix_last = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_last", out_last, 0);
    nreset = 1'b1;
    cycles(2);

    // 1: ratio 3, latency one cycle after the closing beat
    ratio = 4'd3;
    push_exp(60, 3, 1'b0);
    send_n(10, 1'b0); send_n(20, 1'b0);
    chk("t1_no_early", out_valid, 0);
    send_n(30, 1'b0);
    chk("t1_latency", out_valid, 1);
    cycles(2);

    // 2: pix_last closes a short window; next window restarts from zero
    ratio = 4'd4;
    push_exp(510, 2, 1'b1);
    send_n(255, 1'b0); send_n(255, 1'b1);
    push_exp(10, 4, 1'b0);
    send_n(1, 1'b0); send_n(2, 1'b0); send_n(3, 1'b0); send_n(4, 1'b0);
    cycles(2);

    // 3: ratio 1 at full rate
    ratio = 4'd1;
    for (int i = 0; i < 6; i++) begin
      push_exp(i * 7 + 3, 1, 1'b0);
      send(i * 7 + 3, 1'b0, w);
      chk("t3_full_rate", w, 1);
    end
    cycles(2);

    // 4: stall holds result and blocks input, then drains without loss
    ratio = 4'd2;
    out_ready = 1'b0;
    push_exp(3, 2, 1'b0);
    send_n(1, 1'b0); send_n(2, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall_in_ready", in_ready, 0);
      chk("t4_stall_sum", sum, exp_sum(3, 2));
      chk("t4_stall_cnt", cnt, 2);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_exp(7, 2, 1'b0);
    push_exp(11, 2, 1'b0);
    send_n(3, 1'b0); send_n(4, 1'b0); send_n(5, 1'b0); send_n(6, 1'b0);
    cycles(2);

    // 5: clr drops a partial window
    ratio = 4'd5;
    send_n(10, 1'b0); send_n(20, 1'b0); send_n(30, 1'b0);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    cycles(3);
    chk("t5_clr_no_out", out_valid, 0);
    push_exp(15, 5, 1'b0);
    for (int i = 1; i <= 5; i++) send_n(i, 1'b0);
    cycles(2);

    // 5b: clr drops a stalled pending result
    ratio = 4'd1;
    out_ready = 1'b0;
    send_n(9, 1'b0);
    chk("t5b_pending", out_valid, 1);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    chk("t5b_dropped", out_valid, 0);
    out_ready = 1'b1;
    cycles(2);

    // 6: maximum window with maximum pixels, then ratio 0
    ratio = 4'd15;
    push_exp(3825, 15, 1'b0);
    for (int i = 0; i < 15; i++) send_n(255, 1'b0);
    cycles(2);
    ratio = 4'd0;
    push_exp(7, 1, 1'b0);
    push_exp(8, 1, 1'b1);
    send_n(7, 1'b0); send_n(8, 1'b1);
    cycles(2);

    // 7: lowering ratio mid-window closes on the next pixel
    ratio = 4'd8;
    send_n(1, 1'b0); send_n(2, 1'b0); send_n(3, 1'b0);
    ratio = 4'd2;
    push_exp(10, 4, 1'b0);
    send_n(4, 1'b0);
    cycles(2);

    // 8: async reset mid-window discards the partial sum
    ratio = 4'd4;
    send_n(50, 1'b0); send_n(60, 1'b0);
    #3 nreset = 1'b0;
    #2;
    chk("t8_rst_out_valid", out_valid, 0);
    chk("t8_rst_in_ready", in_ready, 1);
    @(posedge clk); #3 nreset = 1'b1;
    @(posedge clk); #1;
    push_exp(10, 4, 1'b0);
    send_n(1, 1'b0); send_n(2, 1'b0); send_n(3, 1'b0); send_n(4, 1'b0);

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    cycles(3);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("final_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
